// File: rtl/pong_pkg.sv
// Shared definitions for the Pong datapath: FSM encoding, LFSR constants and screen size.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPAWN  = 2'd1,
        LIVE   = 2'd2,
        ACTIVE = 2'd3
    } pu_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, expressed as register bits 15/13/12/10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR shared by the random-event blocks.
module lfsr16
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // The all-zero state is a lock-up point; fall back to the seed if it is ever reached.
    always_comb begin
        q_d = lfsr_step(q_q);
        if (q_d == 16'h0000) begin
            q_d = LFSR_SEED;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/powerup_ctrl.sv
// Power-up scheduler: spawns the pack at a random position, detects the ball eating it,
// and times the shield grant for the player who last hit the ball.
//   state  | meaning
//   IDLE   | waiting SPAWN_DELAY frames before the next pack
//   SPAWN  | one-cycle spawn strobe; randx/randy were loaded on entry
//   LIVE   | pack on screen, overlap tested every cycle, withdrawn after LIFETIME frames
//   ACTIVE | shield held for ACTIVE_FRAMES frames
module powerup_ctrl
    import pong_pkg::*;
#(
    parameter int          WIDTH         = 20,
    parameter int          HEIGHT        = 20,
    parameter int          BALL_SIZE     = 16,
    parameter logic [10:0] XMIN          = 11'd256,
    parameter logic [9:0]  YMIN          = 10'd128,
    parameter logic [9:0]  SPAWN_DELAY   = 10'd300,
    parameter logic [9:0]  LIFETIME      = 10'd600,
    parameter logic [9:0]  ACTIVE_FRAMES = 10'd480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_on,
    input  logic        frame_tick,
    input  logic [10:0] ball_x,
    input  logic [9:0]  ball_y,
    input  logic        last_hit,
    output logic        spawn,
    output logic [10:0] randx,
    output logic [9:0]  randy,
    output logic        eaten,
    output logic        shield_p1,
    output logic        shield_p2
);

    pu_state_t   state_q, state_d;
    logic [9:0]  frame_cnt_q, frame_cnt_d;
    logic [10:0] randx_q, randx_d;
    logic [9:0]  randy_q, randy_d;
    logic        spawn_q, spawn_d;
    logic        eaten_q, eaten_d;
    logic        shield_p1_q, shield_p1_d;
    logic        shield_p2_q, shield_p2_d;

    logic [15:0] lfsr_q;
    logic [11:0] px_lo, px_hi, bx_lo, bx_hi;
    logic [10:0] py_lo, py_hi, by_lo, by_hi;
    logic        overlap;
    logic [9:0]  frame_cnt_inc;
    logic        idle_done, live_expire, active_done;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // One bit of headroom on every edge so the sums cannot wrap.
    assign px_lo = {1'b0, randx_q};
    assign px_hi = {1'b0, randx_q} + 12'(WIDTH);
    assign bx_lo = {1'b0, ball_x};
    assign bx_hi = {1'b0, ball_x} + 12'(BALL_SIZE);
    assign py_lo = {1'b0, randy_q};
    assign py_hi = {1'b0, randy_q} + 11'(HEIGHT);
    assign by_lo = {1'b0, ball_y};
    assign by_hi = {1'b0, ball_y} + 11'(BALL_SIZE);

    assign overlap = (bx_lo < px_hi) && (bx_hi > px_lo) && (by_lo < py_hi) && (by_hi > py_lo);

    assign frame_cnt_inc = (frame_cnt_q == 10'h3FF) ? frame_cnt_q : frame_cnt_q + 10'd1;
    assign idle_done     = frame_tick && (frame_cnt_q == SPAWN_DELAY - 10'd1);
    assign live_expire   = frame_tick && (frame_cnt_q == LIFETIME - 10'd1);
    assign active_done   = frame_tick && (frame_cnt_q == ACTIVE_FRAMES - 10'd1);

    always_comb begin
        state_d     = state_q;
        randx_d     = randx_q;
        randy_d     = randy_q;
        spawn_d     = 1'b0;
        eaten_d     = 1'b0;
        shield_p1_d = shield_p1_q;
        shield_p2_d = shield_p2_q;

        if (!game_on) begin
            state_d     = IDLE;
            shield_p1_d = 1'b0;
            shield_p2_d = 1'b0;
            eaten_d     = (state_q == LIVE);
        end else begin
            case (state_q)
                IDLE: begin
                    // Position is loaded on entry to SPAWN so it is valid while spawn is high.
                    if (idle_done) begin
                        state_d = SPAWN;
                        spawn_d = 1'b1;
                        randx_d = XMIN + {2'b00, lfsr_q[8:0]};
                        randy_d = YMIN + {3'b000, lfsr_q[15:9]};
                    end
                end
                SPAWN: begin
                    state_d = LIVE;
                end
                LIVE: begin
                    if (overlap) begin
                        state_d     = ACTIVE;
                        eaten_d     = 1'b1;
                        shield_p1_d = ~last_hit;
                        shield_p2_d = last_hit;
                    end else if (live_expire) begin
                        state_d = IDLE;
                        eaten_d = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (active_done) begin
                        state_d     = IDLE;
                        shield_p1_d = 1'b0;
                        shield_p2_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (!game_on || (state_d != state_q)) begin
            frame_cnt_d = 10'd0;
        end else if (frame_tick) begin
            frame_cnt_d = frame_cnt_inc;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            frame_cnt_q <= 10'd0;
            randx_q     <= 11'd0;
            randy_q     <= 10'd0;
            spawn_q     <= 1'b0;
            eaten_q     <= 1'b0;
            shield_p1_q <= 1'b0;
            shield_p2_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            randx_q     <= randx_d;
            randy_q     <= randy_d;
            spawn_q     <= spawn_d;
            eaten_q     <= eaten_d;
            shield_p1_q <= shield_p1_d;
            shield_p2_q <= shield_p2_d;
        end
    end

    assign spawn     = spawn_q;
    assign randx     = randx_q;
    assign randy     = randy_q;
    assign eaten     = eaten_q;
    assign shield_p1 = shield_p1_q;
    assign shield_p2 = shield_p2_q;

endmodule

// File: tb/tb_powerup_ctrl.sv
// Bench for powerup_ctrl: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a frame-counting reference model.
module tb_powerup_ctrl;

    localparam int W  = 20;
    localparam int H  = 20;
    localparam int BS = 16;
    localparam int XM = 256;
    localparam int YM = 128;
    localparam int SD = 3;
    localparam int LT = 4;
    localparam int AF = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        game_on = 1'b0;
    logic        frame_tick = 1'b0;
    logic [10:0] ball_x = 11'd0;
    logic [9:0]  ball_y = 10'd0;
    logic        last_hit = 1'b0;
    logic        spawn, eaten, shield_p1, shield_p2;
    logic [10:0] randx;
    logic [9:0]  randy;

    always #5 clk = ~clk;

    powerup_ctrl #(
        .WIDTH(W), .HEIGHT(H), .BALL_SIZE(BS),
        .XMIN(11'd256), .YMIN(10'd128),
        .SPAWN_DELAY(10'd3), .LIFETIME(10'd4), .ACTIVE_FRAMES(10'd5)
    ) dut (
        .clk(clk), .reset(reset), .game_on(game_on), .frame_tick(frame_tick),
        .ball_x(ball_x), .ball_y(ball_y), .last_hit(last_hit),
        .spawn(spawn), .randx(randx), .randy(randy), .eaten(eaten),
        .shield_p1(shield_p1), .shield_p2(shield_p2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts ticks seen in each phase and compares with the frame limits.
    typedef enum {P_WAIT, P_STROBE, P_ON, P_SHIELD} mphase_t;
    mphase_t m_phase = P_WAIT;
    int m_ticks = 0, m_lfsr = 'hACE1, m_rx = 0, m_ry = 0;
    bit m_spawn = 0, m_eaten = 0, m_sh1 = 0, m_sh2 = 0;
    int n_grant = 0, n_expire = 0, n_drop = 0;

    function automatic int lfsr_adv(input int s);
        int fb;
        fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
        return ((s << 1) | fb) & 'hFFFF;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = P_WAIT; m_ticks = 0; m_lfsr = 'hACE1; m_rx = 0; m_ry = 0;
            m_spawn = 0; m_eaten = 0; m_sh1 = 0; m_sh2 = 0;
        end else begin
            int cur, bx, by;
            bit ov;
            cur = m_lfsr;
            m_lfsr = lfsr_adv(m_lfsr);
            m_spawn = 0;
            m_eaten = 0;
            if (!game_on) begin
                if (m_phase == P_ON) begin m_eaten = 1; n_drop++; end
                m_phase = P_WAIT; m_ticks = 0; m_sh1 = 0; m_sh2 = 0;
            end else begin
                case (m_phase)
                    P_WAIT: if (frame_tick) begin
                        m_ticks++;
                        if (m_ticks == SD) begin
                            m_spawn = 1; m_rx = XM + cur % 512; m_ry = YM + cur / 512;
                            m_phase = P_STROBE; m_ticks = 0;
                        end
                    end
                    P_STROBE: begin m_phase = P_ON; m_ticks = 0; end
                    P_ON: begin
                        bx = ball_x; by = ball_y;
                        ov = (bx < m_rx + W) && (bx + BS > m_rx) && (by < m_ry + H) && (by + BS > m_ry);
                        if (ov) begin
                            m_eaten = 1; m_sh1 = !last_hit; m_sh2 = last_hit;
                            m_phase = P_SHIELD; m_ticks = 0; n_grant++;
                        end else if (frame_tick) begin
                            m_ticks++;
                            if (m_ticks == LT) begin
                                m_eaten = 1; m_phase = P_WAIT; m_ticks = 0; n_expire++;
                            end
                        end
                    end
                    P_SHIELD: if (frame_tick) begin
                        m_ticks++;
                        if (m_ticks == AF) begin
                            m_sh1 = 0; m_sh2 = 0; m_phase = P_WAIT; m_ticks = 0;
                        end
                    end
                    default: m_phase = P_WAIT;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset) begin
            check("spawn", spawn, m_spawn);
            check("eaten", eaten, m_eaten);
            check("shield_p1", shield_p1, m_sh1);
            check("shield_p2", shield_p2, m_sh2);
            check("randx", randx, m_rx);
            check("randy", randy, m_ry);
            check("shield_excl", shield_p1 & shield_p2, 0);
            if (spawn) begin
                check("randx_range", (randx >= 256 && randx <= 767), 1);
                check("randy_range", (randy >= 128 && randy <= 255), 1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b0;
        step(3);
        check("rst_spawn", spawn, 0);
        check("rst_eaten", eaten, 0);
        check("rst_sh", {shield_p1, shield_p2}, 0);
        check("rst_randx", randx, 0);
        check("rst_randy", randy, 0);

        reset = 1'b1; game_on = 1'b1; frame_tick = 1'b1; last_hit = 1'b1;
        chk_en = 1'b1;
        step(2);  check("a_spawn_early", spawn, 0);
        step(1);  check("a_spawn", spawn, 1);
        check("a_randx", randx, 647);
        check("a_randy", randy, 217);
        ball_x = 11'd657; ball_y = 10'd227;
        step(1);  check("a_eaten_spawncyc", eaten, 0);
        step(1);  check("a_eaten", eaten, 1);
        check("a_p2", shield_p2, 1);
        check("a_p1", shield_p1, 0);
        ball_x = 11'd0; ball_y = 10'd0;
        step(4);  check("a_p2_hold", shield_p2, 1);
        check("a_eaten_once", eaten, 0);
        step(1);  check("a_p2_drop", shield_p2, 0);

        step(3);  check("b_spawn", spawn, 1);
        step(4);  check("b_eaten_early", eaten, 0);
        step(1);  check("b_expire", eaten, 1);
        check("b_noshield", {shield_p1, shield_p2}, 0);
        step(2);  check("b_respawn_early", spawn, 0);
        step(1);  check("b_respawn", spawn, 1);

        ball_x = 11'(m_rx - 16); ball_y = 10'(m_ry); last_hit = 1'b0;
        step(2);  check("c_touch", eaten, 0);
        ball_x = 11'(m_rx - 15);
        step(1);  check("c_overlap", eaten, 1);
        check("c_p1", shield_p1, 1);
        check("c_p2", shield_p2, 0);
        ball_x = 11'd0; ball_y = 10'd0;
        step(1);  check("c_p1_hold", shield_p1, 1);
        reset = 1'b0;
        #1 check("c_async_rst", {shield_p1, shield_p2}, 0);
        step(1);
        reset = 1'b1; last_hit = 1'b1;

        step(2);  check("d_spawn_early", spawn, 0);
        step(1);  check("d_spawn", spawn, 1);
        check("d_randx", randx, 647);
        check("d_randy", randy, 217);
        step(4);  check("d_no_eat", eaten, 0);
        ball_x = 11'd657; ball_y = 10'd227;
        step(1);  check("d_tie_eaten", eaten, 1);
        check("d_tie_p2", shield_p2, 1);
        ball_x = 11'd0; ball_y = 10'd0;
        step(1);  check("d_tie_once", eaten, 0);
        check("d_tie_hold", shield_p2, 1);
        step(3);  check("d_p2_hold", shield_p2, 1);
        step(1);  check("d_p2_drop", shield_p2, 0);

        step(3);  check("e_spawn", spawn, 1);
        step(1);  check("e_live", spawn, 0);
        game_on = 1'b0;
        step(1);  check("e_drop_eaten", eaten, 1);
        step(1);  check("e_drop_once", eaten, 0);
        step(5);  check("e_no_spawn", spawn, 0);
        game_on = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            reset      = ($urandom_range(0, 699) != 0);
            game_on    = ($urandom_range(0, 49) != 0);
            frame_tick = 1'($urandom_range(0, 1));
            last_hit   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 2) begin
                ball_x = 11'(m_rx + int'($urandom_range(0, 38)) - 17);
                ball_y = 10'(m_ry + int'($urandom_range(0, 38)) - 17);
            end else begin
                ball_x = 11'($urandom_range(0, 200));
                ball_y = 10'($urandom_range(0, 100));
            end
            step(1);
        end
        reset = 1'b1;
        step(2);

        check("cov_grant", n_grant > 2, 1);
        check("cov_expire", n_expire > 1, 1);
        check("cov_drop", n_drop > 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
